// File: rtl/niossoc_switch_debounce.sv
// rtl/niossoc_switch_debounce.sv - 2-flop synchronizer and tick-sampled debouncer for slide switches
module niossoc_switch_debounce #(
    parameter int               WIDTH      = 18,
    parameter int               TICK_DIV   = 50000,
    parameter int               STABLE_CNT = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic             sw_changed,
    output logic [WIDTH-1:0] change_mask
);

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CNT - 1);

    logic [WIDTH-1:0]          sync1_q, sync2_q;
    logic [WIDTH-1:0]          sw_out_q, sw_out_d;
    logic                      sw_changed_q, sw_changed_d;
    logic [WIDTH-1:0]          change_mask_q, change_mask_d;
    logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
    logic                      tick_q, tick_d;
    logic [WIDTH-1:0][CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]          flip;

    always_comb begin
        tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
        tick_d     = (tick_cnt_q == TICK_LAST);
        cnt_d      = cnt_q;
        flip       = '0;
        // Filter counters only advance in the single tick cycle of each period.
        if (tick_q) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] == sw_out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    flip[i]  = 1'b1;
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        sw_out_d      = sw_out_q ^ flip;
        sw_changed_d  = |flip;
        change_mask_d = (|flip) ? flip : change_mask_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q       <= RESET_VAL;
            sync2_q       <= RESET_VAL;
            sw_out_q      <= RESET_VAL;
            sw_changed_q  <= 1'b0;
            change_mask_q <= '0;
            tick_cnt_q    <= '0;
            tick_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= sw_in;
            sync2_q       <= sync1_q;
            sw_out_q      <= sw_out_d;
            sw_changed_q  <= sw_changed_d;
            change_mask_q <= change_mask_d;
            tick_cnt_q    <= tick_cnt_d;
            tick_q        <= tick_d;
            cnt_q         <= cnt_d;
        end
    end

    assign sw_out      = sw_out_q;
    assign sw_changed  = sw_changed_q;
    assign change_mask = change_mask_q;

endmodule

// File: tb/tb_niossoc_switch_debounce.sv
// tb/tb_niossoc_switch_debounce.sv - directed table-driven bench for niossoc_switch_debounce
module tb_niossoc_switch_debounce;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] sw_in;
    logic [17:0] sw_out;
    logic        sw_changed;
    logic [17:0] change_mask;

    int n_checks = 0;
    int n_bad    = 0;

    niossoc_switch_debounce #(
        .WIDTH(18), .TICK_DIV(4), .STABLE_CNT(3), .RESET_VAL(18'h0)
    ) dut (
        .clk(clk), .reset(reset), .sw_in(sw_in),
        .sw_out(sw_out), .sw_changed(sw_changed), .change_mask(change_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] in_val;
        logic [17:0] exp_out;
        logic [17:0] exp_mask;
        int          exp_pulses;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_window(input int n, output int pulses, output logic [17:0] mask_at);
        pulses  = 0;
        mask_at = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (sw_changed) begin
                pulses++;
                mask_at = change_mask;
            end
        end
    endtask

    int          pulses;
    logic [17:0] mask_at;
    int          gap;

    initial begin
        vecs[0] = '{18'h00000, 18'h00000, 18'h3FFFF, 1};
        vecs[1] = '{18'h00001, 18'h00001, 18'h00001, 1};
        vecs[2] = '{18'h20003, 18'h20003, 18'h20002, 1};
        vecs[3] = '{18'h20003, 18'h20003, 18'h20002, 0};
        vecs[4] = '{18'h0FF00, 18'h0FF00, 18'h2FF03, 1};

        // T1 reset with all switches high
        reset = 1'b1;
        sw_in = 18'h3FFFF;
        repeat (3) @(negedge clk);
        check("t1_rst_out", 32'(sw_out), 32'h0);
        check("t1_rst_chg", 32'(sw_changed), 32'h0);
        check("t1_rst_mask", 32'(change_mask), 32'h0);
        reset = 1'b0;
        run_window(20, pulses, mask_at);
        check("t1_pulses", 32'(pulses), 32'd1);
        check("t1_out", 32'(sw_out), 32'h3FFFF);
        check("t1_mask", 32'(mask_at), 32'h3FFFF);

        // table vectors: clean steps, simultaneous bits, no-change hold
        for (int v = 0; v < 5; v++) begin
            sw_in = vecs[v].in_val;
            run_window(20, pulses, mask_at);
            check($sformatf("vec%0d_pulses", v), 32'(pulses), 32'(vecs[v].exp_pulses));
            check($sformatf("vec%0d_out", v), 32'(sw_out), 32'(vecs[v].exp_out));
            check($sformatf("vec%0d_mask", v), 32'(change_mask), 32'(vecs[v].exp_mask));
        end

        // T3 bounce on bit 5: toggles every 3 cycles for 40 cycles
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) sw_in[5] = ~sw_in[5];
            @(negedge clk);
            if (sw_changed) pulses++;
        end
        sw_in[5] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sw_changed) pulses++;
        end
        check("t3_pulses", 32'(pulses), 32'd0);
        check("t3_out", 32'(sw_out), 32'h0FF00);

        // T5 reset while bit 9 change is pending (sw_out bit 9 is currently 1)
        sw_in = 18'h0FD00;
        repeat (9) @(negedge clk);
        check("t5_not_yet", 32'(sw_out), 32'h0FF00);
        reset = 1'b1;
        #1;
        check("t5_async_out", 32'(sw_out), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        sw_in = 18'h00200;
        repeat (10) @(negedge clk);
        check("t5_full_qual", 32'(sw_out), 32'h0);
        run_window(10, pulses, mask_at);
        check("t5_pulses", 32'(pulses), 32'd1);
        check("t5_out", 32'(sw_out), 32'h00200);
        check("t5_mask", 32'(mask_at), 32'h00200);

        // T6 tick period over 10 periods
        gap = 0;
        while (!dut.tick_q && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("t6_tick_seen", 32'(dut.tick_q), 32'd1);
        for (int p = 0; p < 10; p++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!dut.tick_q && gap < 20);
            check($sformatf("t6_period%0d", p), 32'(gap), 32'd4);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
